// File: rtl/pc_axi_pkg.sv
// Shared types and constants for the performance-counter AXI store writer.
// Bit indices of err_flags and the writer FSM encoding live here.
package pc_axi_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_AW      = 3'd2,
    S_W       = 3'd3,
    S_B       = 3'd4
  } pc_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  localparam int PC_BEAT_BYTES = 16;

  localparam int ERR_OVF     = 0;
  localparam int ERR_SIZE    = 1;
  localparam int ERR_RESP    = 2;
  localparam int ERR_TIMEOUT = 3;

  function automatic int beat_bytes(input int adw);
    return adw / 8;
  endfunction

endpackage

// File: rtl/pc_beat_fifo.sv
// Beat buffer for the store writer: DEPTH x W synchronous FIFO.
// Push and pop may share a cycle; flush empties it in one cycle.
module pc_beat_fifo #(
  parameter int W     = 128,
  parameter int DEPTH = 8,
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign dout    = mem_q[rd_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = nxt(wr_q);
      if (do_pop)  rd_d = nxt(rd_q);
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/pc_store_axi_writer.sv
// Buffers perf-counter beats and writes them to DDR as one AXI4 INCR burst.
// Define PC_WR_TIMEOUT_EN to enable the B-channel watchdog.
module pc_store_axi_writer
  import pc_axi_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = 128,
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int MAX_BEATS      = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [AXI_DATA_WIDTH-1:0]   st_data,
  input  logic                        st_data_v,
  input  logic [AXI_ADDR_WIDTH-1:0]   st_addr,
  input  logic                        st_addr_v,
  input  logic [AXI_DATA_WIDTH-1:0]   st_size,
  output logic                        up_awready,
  output logic                        up_bvalid,
  input  logic                        err_clear,
  output logic [3:0]                  err_flags,
  output logic [AXI_ADDR_WIDTH-1:0]   m_awaddr,
  output logic [7:0]                  m_awlen,
  output logic [2:0]                  m_awsize,
  output logic [1:0]                  m_awburst,
  output logic                        m_awvalid,
  input  logic                        m_awready,
  output logic [AXI_DATA_WIDTH-1:0]   m_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] m_wstrb,
  output logic                        m_wlast,
  output logic                        m_wvalid,
  input  logic                        m_wready,
  input  logic [1:0]                  m_bresp,
  input  logic                        m_bvalid,
  output logic                        m_bready
);

  localparam int ADW = AXI_DATA_WIDTH;
  localparam int AAW = AXI_ADDR_WIDTH;
  localparam int BSH = $clog2(beat_bytes(ADW));
  localparam int CW  = $clog2(MAX_BEATS + 1);

  pc_state_e      state_q, state_d;
  logic [AAW-1:0] awaddr_q, awaddr_d;
  logic [7:0]     awlen_q, awlen_d;
  logic           awvalid_q, awvalid_d;
  logic           upaw_q, upaw_d;
  logic           upb_q, upb_d;
  logic           zb_q, zb_d;
  logic [3:0]     err_q, err_d;
  logic [3:0]     err_set;

  logic           f_push, f_pop, f_flush;
  logic           f_full, f_empty;
  logic [CW-1:0]  f_count;
  logic [ADW-1:0] f_dout;

  logic           collecting;
  logic [CW-1:0]  beats_now;
  logic [ADW-1:0] exp_bytes;
  logic           size_bad;
  logic           aw_hs, w_hs, b_hs;
  logic           to_fire;

  pc_beat_fifo #(
    .W     (ADW),
    .DEPTH (MAX_BEATS)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset_n),
    .push  (f_push),
    .pop   (f_pop),
    .flush (f_flush),
    .din   (st_data),
    .dout  (f_dout),
    .full  (f_full),
    .empty (f_empty),
    .count (f_count)
  );

  assign collecting = (state_q == S_IDLE) || (state_q == S_COLLECT);
  assign f_push     = collecting && st_data_v && !f_full;
  // The beat arriving alongside st_addr_v belongs to this burst.
  assign beats_now  = f_count + CW'(f_push);
  assign exp_bytes  = ADW'(beats_now) << BSH;
  assign size_bad   = (st_size != exp_bytes);

  assign m_wvalid  = (state_q == S_W) && !f_empty;
  assign m_wlast   = m_wvalid && (f_count == CW'(1));
  assign m_wdata   = m_wvalid ? f_dout : '0;
  assign m_wstrb   = {(ADW/8){m_wvalid}};
  assign m_awaddr  = awaddr_q;
  assign m_awlen   = awlen_q;
  assign m_awvalid = awvalid_q;
  assign m_awsize  = 3'(BSH);
  assign m_awburst = AXI_BURST_INCR;

  assign aw_hs   = awvalid_q && m_awready;
  assign w_hs    = m_wvalid && m_wready;
  assign b_hs    = (state_q == S_B) && m_bvalid;
  assign f_pop   = w_hs;
  assign f_flush = b_hs || to_fire;

  assign up_awready = upaw_q;
  assign up_bvalid  = upb_q;
  assign err_flags  = err_q;

`ifdef PC_WR_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt_q;
  logic          stale_q;

  assign to_fire  = (state_q == S_B) && !m_bvalid
                 && (tcnt_q == TW'(TIMEOUT_CYCLES - 1));
  // A late response after a timeout is still accepted, then dropped.
  assign m_bready = (state_q == S_B) || stale_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tcnt_q  <= '0;
      stale_q <= 1'b0;
    end else begin
      tcnt_q  <= (state_q == S_B) ? tcnt_q + TW'(1) : '0;
      if (to_fire)                stale_q <= 1'b1;
      else if (stale_q && m_bvalid) stale_q <= 1'b0;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign to_fire        = 1'b0;
  assign m_bready       = (state_q == S_B);
`endif

  always_comb begin
    state_d   = state_q;
    awaddr_d  = awaddr_q;
    awlen_d   = awlen_q;
    awvalid_d = awvalid_q;
    upaw_d    = 1'b0;
    upb_d     = zb_q;
    zb_d      = 1'b0;
    err_set   = '0;
    if (st_data_v && !f_push) err_set[ERR_OVF] = 1'b1;
    if (st_addr_v && (!collecting || size_bad)) err_set[ERR_SIZE] = 1'b1;
    unique case (state_q)
      S_IDLE, S_COLLECT: begin
        if (st_addr_v) begin
          if (beats_now == '0) begin
            upaw_d            = 1'b1;
            zb_d              = 1'b1;
            err_set[ERR_SIZE] = 1'b1;
          end else begin
            awaddr_d  = st_addr;
            awlen_d   = 8'(beats_now - CW'(1));
            awvalid_d = 1'b1;
            state_d   = S_AW;
          end
        end else if (f_push) begin
          state_d = S_COLLECT;
        end
      end
      S_AW: begin
        if (aw_hs) begin
          awvalid_d = 1'b0;
          upaw_d    = 1'b1;
          state_d   = S_W;
        end
      end
      S_W: begin
        if (w_hs && m_wlast) state_d = S_B;
      end
      S_B: begin
        if (b_hs) begin
          upb_d   = 1'b1;
          state_d = S_IDLE;
          if (m_bresp != AXI_RESP_OKAY) err_set[ERR_RESP] = 1'b1;
        end else if (to_fire) begin
          upb_d                = 1'b1;
          state_d              = S_IDLE;
          err_set[ERR_TIMEOUT] = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    err_d = err_clear ? '0 : (err_q | err_set);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      awaddr_q  <= '0;
      awlen_q   <= '0;
      awvalid_q <= 1'b0;
      upaw_q    <= 1'b0;
      upb_q     <= 1'b0;
      zb_q      <= 1'b0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      awaddr_q  <= awaddr_d;
      awlen_q   <= awlen_d;
      awvalid_q <= awvalid_d;
      upaw_q    <= upaw_d;
      upb_q     <= upb_d;
      zb_q      <= zb_d;
      err_q     <= err_d;
    end
  end

endmodule
